alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised multi-cycle ALU with integrated operation decode for the multi-cycle RISC-V datapath.
//  Decodes ALUOp/funct3/funct7 to a full RV32I ALU op set plus optional MUL.
//  Executes single-cycle ops in 1 cycle, shifts iteratively and MUL by shift-add, under a start/done handshake.
//  Sits between the main control FSM (issues start, waits on done) and the ALUOut register path.
// PARAMETERS
//  XLEN             32  operand/result width; power of 2, >= 8
//  SHIFT_PER_CYCLE  1   bit positions shifted per cycle in SHIFT state; power of 2, 1..XLEN
//  ENABLE_MUL       1   1: funct7=0000001,funct3=000 executes MUL; 0: that encoding is illegal
// PORTS
//  clk      in   1     clock, all state on rising edge
//  rst_n    in   1     asynchronous active-low reset
//  start    in   1     op request; accepted only when busy=0
//  ALUOp    in   2     00 ADD, 01 SUB, 10 R-type (funct3/funct7), 11 I-type (funct3; funct7 for shifts only)
//  funct3   in   3     instruction funct3
//  funct7   in   7     instruction funct7
//  a        in   XLEN  operand A
//  b        in   XLEN  operand B / immediate; shamt = b[$clog2(XLEN)-1:0]
//  busy     out  1     1 while an accepted op is executing (cycle after accept until done cycle)
//  done     out  1     1-cycle pulse: result/zero/illegal valid
//  result   out  XLEN  op result; holds value until next done
//  zero     out  1     result == 0, updated with result
//  illegal  out  1     encoding not supported; valid with done
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, result=0, zero=1, illegal=0; internal regs cleared.
//  Accept: start=1 and busy=0 at rising edge; ALUOp/funct3/funct7/a/b captured. start while busy ignored.
//  Decode (R-type; I-type identical except funct7 ignored for non-shifts and no SUB/MUL):
//   000 ADD, SUB if funct7=0100000 (R only); 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 SRL (funct7=0000000) / SRA (0100000); 110 OR; 111 AND; funct7=0000001&funct3=000 MUL (R only).
//   Any other funct7 on R-type, other funct7 on I-type shifts, M-ext funct3!=000 -> illegal.
//  Arithmetic: all mod 2^XLEN; SLT signed, SLTU unsigned, result 0/1 zero-extended; SRA sign-fills;
//   MUL returns low XLEN bits of a*b (sign-agnostic).
//  FSM: IDLE -> EXEC (single-cycle/illegal) -> IDLE; IDLE -> SHIFT -> IDLE; IDLE -> MUL -> IDLE.
//   EXEC: result computed; done=1 the cycle after accept. Latency 1.
//   Illegal: same timing as EXEC; result=0, zero=1, illegal=1.
//   SHIFT: shamt=0 -> done at cycle 1; else remaining count decrements by min(SHIFT_PER_CYCLE,remaining)
//    per cycle; done on the cycle the count reaches 0. Latency = max(1, ceil(shamt/SHIFT_PER_CYCLE)).
//   MUL: XLEN iterations of shift-add, one multiplier bit per cycle; latency XLEN (done at cycle XLEN).
//  Handshake: busy=1 from cycle after accept through the done cycle; busy=0 otherwise.
//   Back-to-back: start in the same cycle as done is accepted after the done cycle.
//  done cycle: result, zero, illegal updated together; illegal cleared on next done of a legal op.
//  Reset mid-op: op aborted, all outputs to reset values, no done pulse; next start accepted normally.
//  Input changes after accept have no effect on the running op.
// TESTING
//  1. ALUOp=00, a=5, b=7, start -> done at cycle 1, result=12, zero=0, busy=1 only in that cycle.
//  2. ALUOp=10, f3=000, f7=0100000, a=b=0x1234 -> result=0, zero=1; a=0, b=1 SLT f3=010 -> result=1.
//  3. ALUOp=11, f3=101, f7=0100000, a=0x80000000, b=31, SPC=1 -> done at cycle 31, result=0xFFFFFFFF;
//     repeat SPC=4 -> done at cycle 8; shamt=0 -> done at cycle 1, result=a.
//  4. ALUOp=10, f7=0000001, f3=000, a=0xFFFFFFFF, b=3 -> done at cycle 32, result=0xFFFFFFFD;
//     ENABLE_MUL=0 -> done at cycle 1, illegal=1, result=0.
//  5. MUL in progress, pulse start with ADD at cycles 5..10 -> ignored; only MUL done observed.
//  6. Assert rst_n=0 at cycle 10 of MUL -> busy=0, done never pulses, result=0; ADD after release completes normally.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Multi-cycle RV32I ALU with built-in ALUOp/funct3/funct7 decode.
// Single-cycle ops finish in one cycle, shifts run iteratively and MUL by shift-add, under start/done.
module alu_seq_unit #(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1,
    parameter int ENABLE_MUL      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    localparam logic [CW-1:0] SPC_C   = CW'(SHIFT_PER_CYCLE);
    localparam logic [CW-1:0] XLEN_C  = CW'(XLEN);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [6:0]    F7_BASE = 7'b0000000;
    localparam logic [6:0]    F7_ALT  = 7'b0100000;
    localparam logic [6:0]    F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_MUL   = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_MUL  = 4'd10,
        OP_ILL  = 4'd11
    } op_t;

    function automatic op_t base_op(input logic [2:0] f3);
        op_t op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic op_t decode_op(input logic [1:0] alu_op, input logic [2:0] f3,
                                      input logic [6:0] f7);
        op_t op;
        op = OP_ILL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                if (f7 == F7_MEXT) begin
                    if ((f3 == 3'b000) && (ENABLE_MUL != 32'sd0)) begin
                        op = OP_MUL;
                    end else begin
                        op = OP_ILL;
                    end
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  op = OP_SUB;
                        3'b101:  op = OP_SRA;
                        default: op = OP_ILL;
                    endcase
                end else if (f7 == F7_BASE) begin
                    op = base_op(f3);
                end else begin
                    op = OP_ILL;
                end
            end
            default: begin
                // I-type: funct7 only qualifies the shift encodings
                case (f3)
                    3'b001: begin
                        if (f7 == F7_BASE) begin
                            op = OP_SLL;
                        end else begin
                            op = OP_ILL;
                        end
                    end
                    3'b101: begin
                        if (f7 == F7_BASE) begin
                            op = OP_SRL;
                        end else if (f7 == F7_ALT) begin
                            op = OP_SRA;
                        end else begin
                            op = OP_ILL;
                        end
                    end
                    default: op = base_op(f3);
                endcase
            end
        endcase
        return op;
    endfunction

    function automatic logic [XLEN-1:0] alu_exec(input op_t op, input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
        logic [XLEN-1:0] r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
            OP_XOR:  r = x ^ y;
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t          state_r, state_nxt;
    op_t             op_r, op_nxt;
    logic            busy_r, busy_nxt;
    logic            done_r, done_nxt;
    logic [XLEN-1:0] result_r, result_nxt;
    logic            zero_r, zero_nxt;
    logic            illegal_r, illegal_nxt;
    logic [XLEN-1:0] val_r, val_nxt;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    logic [XLEN-1:0] mcd_r, mcd_nxt;
    logic [XLEN-1:0] mpl_r, mpl_nxt;

    logic            idle_s;
    op_t             dec_op_s;
    op_t             cur_op_s;
    logic [XLEN-1:0] src_val_s;
    logic [CW-1:0]   src_cnt_s;
    logic [XLEN-1:0] src_mcd_s;
    logic [XLEN-1:0] src_mpl_s;
    logic [CW-1:0]   step_s;
    logic [XLEN-1:0] shift_val_s;
    logic [CW-1:0]   shift_cnt_s;
    logic [XLEN-1:0] mul_acc_s;
    logic [CW-1:0]   mul_cnt_s;
    logic [XLEN-1:0] exec_res_s;
    logic            fin_s;
    logic [XLEN-1:0] fin_res_s;
    logic            fin_ill_s;

    // The first iteration runs on the accept edge straight from the inputs, so latency counts from there
    assign idle_s      = (state_r == S_IDLE);
    assign dec_op_s    = decode_op(ALUOp, funct3, funct7);
    assign cur_op_s    = idle_s ? dec_op_s : op_r;
    assign src_val_s   = idle_s ? ((dec_op_s == OP_MUL) ? '0 : a) : val_r;
    assign src_cnt_s   = idle_s ? ((dec_op_s == OP_MUL) ? XLEN_C : {1'b0, b[SHW-1:0]}) : cnt_r;
    assign src_mcd_s   = idle_s ? a : mcd_r;
    assign src_mpl_s   = idle_s ? b : mpl_r;
    assign step_s      = (src_cnt_s > SPC_C) ? SPC_C : src_cnt_s;
    assign shift_cnt_s = src_cnt_s - step_s;
    assign mul_acc_s   = src_val_s + (src_mpl_s[0] ? src_mcd_s : '0);
    assign mul_cnt_s   = src_cnt_s - ONE_C;
    assign exec_res_s  = alu_exec(dec_op_s, a, b);

    // One shift step of up to SHIFT_PER_CYCLE positions in the direction of the current op
    always_comb begin
        shift_val_s = src_val_s;
        case (cur_op_s)
            OP_SLL:  shift_val_s = src_val_s << step_s;
            OP_SRA:  shift_val_s = $signed(src_val_s) >>> step_s;
            default: shift_val_s = src_val_s >> step_s;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state_r;
        op_nxt      = op_r;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        result_nxt  = result_r;
        zero_nxt    = zero_r;
        illegal_nxt = illegal_r;
        val_nxt     = val_r;
        cnt_nxt     = cnt_r;
        mcd_nxt     = mcd_r;
        mpl_nxt     = mpl_r;
        fin_s       = 1'b0;
        fin_res_s   = '0;
        fin_ill_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_nxt = 1'b1;
                    op_nxt   = dec_op_s;
                    case (dec_op_s)
                        OP_ILL: begin
                            fin_s     = 1'b1;
                            fin_ill_s = 1'b1;
                            state_nxt = S_EXEC;
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            val_nxt = shift_val_s;
                            cnt_nxt = shift_cnt_s;
                            if (shift_cnt_s == '0) begin
                                fin_s     = 1'b1;
                                fin_res_s = shift_val_s;
                                state_nxt = S_EXEC;
                            end else begin
                                state_nxt = S_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            val_nxt   = mul_acc_s;
                            cnt_nxt   = mul_cnt_s;
                            mcd_nxt   = src_mcd_s << 1;
                            mpl_nxt   = src_mpl_s >> 1;
                            state_nxt = S_MUL;
                        end
                        default: begin
                            fin_s     = 1'b1;
                            fin_res_s = exec_res_s;
                            state_nxt = S_EXEC;
                        end
                    endcase
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_EXEC: state_nxt = S_IDLE;
            S_SHIFT: begin
                // cnt_r == 0 marks the done cycle, which ends the op
                if (cnt_r == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    busy_nxt = 1'b1;
                    val_nxt  = shift_val_s;
                    cnt_nxt  = shift_cnt_s;
                    if (shift_cnt_s == '0) begin
                        fin_s     = 1'b1;
                        fin_res_s = shift_val_s;
                    end else begin
                        fin_s = 1'b0;
                    end
                end
            end
            S_MUL: begin
                if (cnt_r == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    busy_nxt = 1'b1;
                    val_nxt  = mul_acc_s;
                    cnt_nxt  = mul_cnt_s;
                    mcd_nxt  = src_mcd_s << 1;
                    mpl_nxt  = src_mpl_s >> 1;
                    if (mul_cnt_s == '0) begin
                        fin_s     = 1'b1;
                        fin_res_s = mul_acc_s;
                    end else begin
                        fin_s = 1'b0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (fin_s) begin
            done_nxt    = 1'b1;
            result_nxt  = fin_res_s;
            zero_nxt    = (fin_res_s == '0);
            illegal_nxt = fin_ill_s;
        end else begin
            done_nxt = 1'b0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_r      <= OP_ADD;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            zero_r    <= 1'b1;
            illegal_r <= 1'b0;
            val_r     <= '0;
            cnt_r     <= '0;
            mcd_r     <= '0;
            mpl_r     <= '0;
        end else begin
            state_r   <= state_nxt;
            op_r      <= op_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            result_r  <= result_nxt;
            zero_r    <= zero_nxt;
            illegal_r <= illegal_nxt;
            val_r     <= val_nxt;
            cnt_r     <= cnt_nxt;
            mcd_r     <= mcd_nxt;
            mpl_r     <= mpl_nxt;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign zero    = zero_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: three instances (SPC=1, SPC=4, no MUL) share one stimulus stream.
module tb_alu_seq_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic [1:0]  alu_op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;

    logic        busy_m, done_m, zero_m, illegal_m;
    logic [31:0] result_m;
    logic        busy_q, done_q, zero_q, illegal_q;
    logic [31:0] result_q;
    logic        busy_n, done_n, zero_n, illegal_n;
    logic [31:0] result_n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_unit #(.XLEN(32), .SHIFT_PER_CYCLE(1), .ENABLE_MUL(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .funct3(f3), .funct7(f7),
        .a(a), .b(b), .busy(busy_m), .done(done_m), .result(result_m), .zero(zero_m),
        .illegal(illegal_m));

    alu_seq_unit #(.XLEN(32), .SHIFT_PER_CYCLE(4), .ENABLE_MUL(1)) dut_q (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .funct3(f3), .funct7(f7),
        .a(a), .b(b), .busy(busy_q), .done(done_q), .result(result_q), .zero(zero_q),
        .illegal(illegal_q));

    alu_seq_unit #(.XLEN(32), .SHIFT_PER_CYCLE(1), .ENABLE_MUL(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .funct3(f3), .funct7(f7),
        .a(a), .b(b), .busy(busy_n), .done(done_n), .result(result_n), .zero(zero_n),
        .illegal(illegal_n));

    typedef struct {
        logic [1:0]  alu_op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic        is_mul;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat_m, lat_q, lat_n, seq_err;
        logic [31:0] r_m, r_q, r_n;
        logic        z_m, i_m, i_n;
        logic [31:0] exp_res_n;
        logic        exp_ill_n;
        int          exp_lat_n;
        lat_m = 0; lat_q = 0; lat_n = 0; seq_err = 0;
        r_m = '0; r_q = '0; r_n = '0; z_m = 1'b0; i_m = 1'b0; i_n = 1'b0;
        @(negedge clk);
        alu_op = v.alu_op; f3 = v.f3; f7 = v.f7; a = v.a; b = v.b; start = 1'b1;
        @(negedge clk);
        // scramble inputs after accept; the running op must not notice
        start = 1'b0; alu_op = ~v.alu_op; f3 = ~v.f3; f7 = ~v.f7; a = ~v.a; b = ~v.b;
        for (int c = 1; c <= 100; c++) begin
            if (lat_m == 0) begin
                if (busy_m !== 1'b1) seq_err++;
                if (done_m === 1'b1) begin
                    lat_m = c; r_m = result_m; z_m = zero_m; i_m = illegal_m;
                end
            end else begin
                if (busy_m !== 1'b0 || done_m !== 1'b0 || result_m !== r_m) seq_err++;
            end
            if (lat_q == 0 && done_q === 1'b1) begin
                lat_q = c; r_q = result_q;
            end
            if (lat_n == 0 && done_n === 1'b1) begin
                lat_n = c; r_n = result_n; i_n = illegal_n;
            end
            if (lat_m != 0 && lat_q != 0 && lat_n != 0 && c > lat_m) break;
            @(negedge clk);
        end
        exp_res_n = v.is_mul ? 32'h0 : v.res;
        exp_ill_n = v.is_mul ? 1'b1 : v.ill;
        exp_lat_n = v.is_mul ? 1 : v.lat1;
        chk($sformatf("v%0d result", idx), r_m, v.res);
        chk($sformatf("v%0d zero", idx), {31'd0, z_m}, {31'd0, (v.res == 32'h0)});
        chk($sformatf("v%0d illegal", idx), {31'd0, i_m}, {31'd0, v.ill});
        chk($sformatf("v%0d latency", idx), lat_m, v.lat1);
        chk($sformatf("v%0d busy/hold errors", idx), seq_err, 0);
        chk($sformatf("v%0d spc4 result", idx), r_q, v.res);
        chk($sformatf("v%0d spc4 latency", idx), lat_q, v.lat4);
        chk($sformatf("v%0d nomul result", idx), r_n, exp_res_n);
        chk($sformatf("v%0d nomul illegal", idx), {31'd0, i_n}, {31'd0, exp_ill_n});
        chk($sformatf("v%0d nomul latency", idx), lat_n, exp_lat_n);
    endtask

    initial begin
        int          n_done_m, n_done_q, first_m, first_q, n_done_r;
        logic [31:0] r_m, r_q;

        //           op     f3      f7     a             b             result        ill   mul   l1  l4
        vecs[0]  = '{2'b00, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1,  1};
        vecs[1]  = '{2'b01, 3'b000, 7'h00, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1,  1};
        vecs[2]  = '{2'b10, 3'b000, 7'h20, 32'h1234,     32'h1234,     32'h0,        1'b0, 1'b0, 1,  1};
        vecs[3]  = '{2'b10, 3'b010, 7'h00, 32'd0,        32'd1,        32'd1,        1'b0, 1'b0, 1,  1};
        vecs[4]  = '{2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1,  1};
        vecs[5]  = '{2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1,  1};
        vecs[6]  = '{2'b10, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1,  1};
        vecs[7]  = '{2'b11, 3'b110, 7'h55, 32'h0000F000, 32'h00000F0F, 32'h0000FF0F, 1'b0, 1'b0, 1,  1};
        vecs[8]  = '{2'b10, 3'b111, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1,  1};
        vecs[9]  = '{2'b10, 3'b001, 7'h00, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 31, 8};
        vecs[10] = '{2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 4,  1};
        vecs[11] = '{2'b11, 3'b101, 7'h20, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 31, 8};
        vecs[12] = '{2'b11, 3'b101, 7'h20, 32'h80000000, 32'd32,       32'h80000000, 1'b0, 1'b0, 1,  1};
        vecs[13] = '{2'b11, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd5,        32'h07FFFFFF, 1'b0, 1'b0, 5,  2};
        vecs[14] = '{2'b11, 3'b000, 7'h7F, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1,  1};
        vecs[15] = '{2'b11, 3'b011, 7'h00, 32'd1,        32'd2,        32'd1,        1'b0, 1'b0, 1,  1};
        vecs[16] = '{2'b11, 3'b001, 7'h20, 32'd1,        32'd3,        32'h0,        1'b1, 1'b0, 1,  1};
        vecs[17] = '{2'b10, 3'b000, 7'h10, 32'd1,        32'd3,        32'h0,        1'b1, 1'b0, 1,  1};
        vecs[18] = '{2'b10, 3'b001, 7'h01, 32'd4,        32'd3,        32'h0,        1'b1, 1'b0, 1,  1};
        vecs[19] = '{2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 1'b1, 32, 32};
        vecs[20] = '{2'b10, 3'b000, 7'h01, 32'h00012345, 32'h100,      32'h01234500, 1'b0, 1'b1, 32, 32};
        vecs[21] = '{2'b11, 3'b000, 7'h20, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0, 1,  1};
        vecs[22] = '{2'b10, 3'b101, 7'h20, 32'h70000000, 32'd8,        32'h00700000, 1'b0, 1'b0, 8,  2};

        rst_n = 1'b0; start = 1'b0; alu_op = 2'b00; f3 = 3'b000; f7 = 7'h00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy_m}, 32'd0);
        chk("reset done", {31'd0, done_m}, 32'd0);
        chk("reset result", result_m, 32'h0);
        chk("reset zero", {31'd0, zero_m}, 32'd1);
        chk("reset illegal", {31'd0, illegal_m}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) run_vec(vecs[i], i);

        // MUL running while start pulses with an ADD: only the MUL completes
        @(negedge clk);
        alu_op = 2'b10; f3 = 3'b000; f7 = 7'h01; a = 32'd7; b = 32'd6; start = 1'b1;
        n_done_m = 0; n_done_q = 0; first_m = 0; first_q = 0; r_m = '0; r_q = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin
                n_done_m++; r_m = result_m;
                if (first_m == 0) first_m = c;
            end
            if (done_q === 1'b1) begin
                n_done_q++; r_q = result_q;
                if (first_q == 0) first_q = c;
            end
            if (c >= 4 && c <= 9) begin
                start = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy-start done count", n_done_m, 1);
        chk("busy-start latency", first_m, 32);
        chk("busy-start result", r_m, 32'd42);
        chk("busy-start spc4 done count", n_done_q, 1);
        chk("busy-start spc4 result", r_q, 32'd42);

        // Reset in the middle of a MUL, with illegal still set from the previous op
        run_vec(vecs[17], 100);
        @(negedge clk);
        alu_op = 2'b10; f3 = 3'b000; f7 = 7'h01; a = 32'd3; b = 32'd5; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, busy_m}, 32'd0);
        chk("midreset done", {31'd0, done_m}, 32'd0);
        chk("midreset result", result_m, 32'h0);
        chk("midreset zero", {31'd0, zero_m}, 32'd1);
        chk("midreset illegal", {31'd0, illegal_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done_r = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_m === 1'b1 || busy_m === 1'b1) n_done_r++;
        end
        chk("midreset no done/busy after", n_done_r, 0);
        run_vec(vecs[0], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
